// File: rtl/fifo_control.sv
// fifo_control: pointer/flag controller for a dual-port FIFO memory with registered read
// Ports: clk, reset (sync, active-high); push/pop requests in; write_enable/read_enable and
// write_addr/read_addr to the memory; full/empty/almost_full/almost_empty/fifo_count status;
// data_valid marks the memory output one cycle after an accepted pop; error is sticky.
module fifo_control #(
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  output logic       write_enable,
  output logic       read_enable,
  output logic [3:0] write_addr,
  output logic [3:0] read_addr,
  output logic       full,
  output logic       empty,
  output logic       almost_full,
  output logic       almost_empty,
  output logic [4:0] fifo_count,
  output logic       data_valid,
  output logic       error
);
  logic [3:0] wr_ptr, rd_ptr;
  logic [4:0] count;
  assign empty        = count == 5'd0;
  assign full         = count == 5'(DEPTH);
  assign almost_full  = count >= 5'(AF_THRESH);
  assign almost_empty = count <= 5'(AE_THRESH);
  assign fifo_count   = count;
  assign write_addr   = wr_ptr;
  assign read_addr    = rd_ptr;
  assign read_enable  = pop & ~empty;
  assign write_enable = push & (~full | read_enable);
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data_valid <= 1'b0;
      error      <= 1'b0;
    end else begin
      if (write_enable) wr_ptr <= wr_ptr == 4'(DEPTH - 1) ? 4'd0 : wr_ptr + 4'd1;
      if (read_enable) rd_ptr <= rd_ptr == 4'(DEPTH - 1) ? 4'd0 : rd_ptr + 4'd1;
      count      <= count + 5'(write_enable) - 5'(read_enable);
      data_valid <= read_enable;
      error      <= error | (push & full & ~pop) | (pop & empty);
    end
  end
endmodule

// File: tb/tb_fifo_control.sv
// tb_fifo_control: randomized check of fifo_control against a queue-based FIFO model
module tb_fifo_control;
  localparam int DEPTH = 8, AF = 6, AE = 2;
  logic clk = 0, reset = 0, push = 0, pop = 0;
  logic write_enable, read_enable, full, empty, almost_full, almost_empty, data_valid, error;
  logic [3:0] write_addr, read_addr;
  logic [4:0] fifo_count;
  logic [9:0] din = 0, dout, mem [16];
  int tests = 0, fails = 0;
  logic [9:0] q[$];
  int wp = 0, rp = 0;
  bit err = 0, mdv = 0;
  logic [9:0] mword = 0;

  fifo_control #(.DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop),
    .write_enable(write_enable), .read_enable(read_enable),
    .write_addr(write_addr), .read_addr(read_addr),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .fifo_count(fifo_count), .data_valid(data_valid), .error(error));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (write_enable) mem[write_addr] <= din;
    if (read_enable) dout <= mem[read_addr];
  end

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit p, input bit o, input bit r);
    int n;
    bit ra, wa;
    @(negedge clk);
    push = p; pop = o; reset = r; din = 10'($urandom);
    #1;
    n  = q.size();
    ra = o && n > 0;
    wa = p && (n < DEPTH || ra);
    chk("count", fifo_count, n);
    chk("full", full, n == DEPTH);
    chk("empty", empty, n == 0);
    chk("almost_full", almost_full, n >= AF);
    chk("almost_empty", almost_empty, n <= AE);
    chk("write_enable", write_enable, wa);
    chk("read_enable", read_enable, ra);
    chk("write_addr", write_addr, wp);
    chk("read_addr", read_addr, rp);
    chk("data_valid", data_valid, mdv);
    chk("error", error, err);
    if (mdv) chk("dout", dout, mword);
    if (r) begin
      q.delete(); wp = 0; rp = 0; err = 0; mdv = 0;
    end else begin
      err = err | (p && n == DEPTH && !o) | (o && n == 0);
      mdv = ra;
      if (ra) begin mword = q.pop_front(); rp = (rp + 1) % DEPTH; end
      if (wa) begin q.push_back(din); wp = (wp + 1) % DEPTH; end
    end
  endtask

  initial begin
    step(0, 0, 1);
    step(0, 0, 0);
    repeat (DEPTH) step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    repeat (DEPTH + 1) step(0, 1, 0);
    step(0, 0, 0);
    step(0, 0, 1);
    step(1, 1, 0);
    step(0, 0, 0);
    repeat (DEPTH) step(1, 0, 0);
    repeat (10) step(1, 1, 0);
    repeat (DEPTH) step(0, 1, 0);
    step(0, 0, 0);
    repeat (5) step(1, 0, 0);
    step(1, 1, 1);
    step(0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      int mode;
      mode = (i / 250) % 3;
      step($urandom_range(0, 9) < (mode == 0 ? 7 : mode == 1 ? 3 : 5),
           $urandom_range(0, 9) < (mode == 0 ? 3 : mode == 1 ? 7 : 5),
           $urandom_range(0, 199) == 0);
    end
    step(0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
